// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes and per-stage destination metadata.
package pipe_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             memread;
   } stage_meta_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Count updates on the clock edge after inc is seen; never back-pressures.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects, load-use stall and branch-flush squashing for the 5-stage pipe.
// Selects and stall are combinational (zero latency); stall holds IF/ID and injects an EX bubble.
module fwd_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_W = pipe_pkg::REG_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic [1:0]       fwd_sel_a,
   output logic [1:0]       fwd_sel_b,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   stage_meta_t      ex_q;
   stage_meta_t      mem_q;
   stage_meta_t      wb_q;
   logic [REG_W-1:0] ex_rs1;
   logic [REG_W-1:0] ex_rs2;

   // MEM result beats WB result; x0 is hard-wired zero and never forwarded.
   function automatic logic [1:0] fwd_pick(input stage_meta_t      mem,
                                           input stage_meta_t      wb,
                                           input logic [REG_W-1:0] rs);
      if (mem.valid && mem.regwrite && (mem.rd != '0) && (mem.rd == rs)) begin
         return FWD_EXMEM;
      end else if (wb.valid && wb.regwrite && (wb.rd != '0) && (wb.rd == rs)) begin
         return FWD_MEMWB;
      end
      return FWD_RF;
   endfunction

   assign fwd_sel_a = fwd_pick(mem_q, wb_q, ex_rs1);
   assign fwd_sel_b = fwd_pick(mem_q, wb_q, ex_rs2);

   assign stall = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0)
                & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q   <= '0;
         ex_rs1 <= '0;
         ex_rs2 <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
      end else begin
         wb_q  <= mem_q;
         // A flush squashes the branch in EX as well, so MEM takes a bubble.
         mem_q <= flush ? stage_meta_t'('0) : ex_q;
         if (flush || stall) begin
            ex_q   <= '0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
         end else begin
            ex_q   <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
         end
      end
   end

   // The load flag has no consumer once an instruction reaches WB.
   logic unused_wb_memread;
   assign unused_wb_memread = wb_q.memread;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; expectations are queued by the driver and checked by monitors.
module tb_fwd_hazard_unit;

   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [REG_W-1:0] id_rs1 = '0;
   logic [REG_W-1:0] id_rs2 = '0;
   logic [REG_W-1:0] id_rd = '0;
   logic             id_regwrite = 1'b0;
   logic             id_memread = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       fwd_sel_a;
   logic [1:0]       fwd_sel_b;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .fwd_sel_a   (fwd_sel_a),
      .fwd_sel_b   (fwd_sel_b),
      .stall       (stall),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   typedef struct {
      string            name;
      logic [1:0]       sel_a;
      logic [1:0]       sel_b;
      logic             stall;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic compare_one();
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({fwd_sel_a, fwd_sel_b, stall, stall_cnt, flush_cnt} !==
          {e.sel_a, e.sel_b, e.stall, e.scnt, e.fcnt}) begin
         errors++;
         $display("FAIL %s: got sel_a=%b sel_b=%b stall=%b stall_cnt=%0d flush_cnt=%0d, required sel_a=%b sel_b=%b stall=%b stall_cnt=%0d flush_cnt=%0d",
                  e.name, fwd_sel_a, fwd_sel_b, stall, stall_cnt, flush_cnt,
                  e.sel_a, e.sel_b, e.stall, e.scnt, e.fcnt);
      end
   endtask

   // Steady-state outputs are checked mid-cycle; reset response is checked before the next edge.
   always @(negedge clk) if (exp_q.size() != 0) compare_one();
   always @(posedge rst) begin
      #1;
      if (exp_q.size() != 0) compare_one();
   end

   task automatic push_exp(input logic [1:0] ea, input logic [1:0] eb, input logic est,
                           input int esc, input int efc, input string name);
      exp_t e;
      e.name  = name;
      e.sel_a = ea;
      e.sel_b = eb;
      e.stall = est;
      e.scnt  = CNT_W'(esc);
      e.fcnt  = CNT_W'(efc);
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic v, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb, input logic est,
                        input int esc, input int efc, input string name);
      @(posedge clk);
      #1;
      id_valid    = v;
      id_rs1      = REG_W'(rs1);
      id_rs2      = REG_W'(rs2);
      id_rd       = REG_W'(rd);
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
      push_exp(ea, eb, est, esc, efc, name);
   endtask

   task automatic nop(input logic [1:0] ea, input logic [1:0] eb, input logic est,
                      input int esc, input int efc, input string name);
      issue(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, ea, eb, est, esc, efc, name);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      #1;
      id_valid = 1'b0;
      flush    = 1'b0;
      push_exp(2'b00, 2'b00, 1'b0, 0, 0, name);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      // 1: EX/MEM forward on operand A
      do_reset("t1_reset");
      issue(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t1_add_id");
      issue(1, 5, 3, 6, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t1_add_in_ex");
      nop(2'b01, 2'b00, 0, 0, 0, "t1_sub_fwd_a");

      // 2: MEM/WB forward on operand B, then the same shape through x0
      do_reset("t2_reset");
      issue(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t2_add_id");
      nop(2'b00, 2'b00, 0, 0, 0, "t2_add_in_ex");
      issue(1, 4, 5, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t2_nop_in_ex");
      nop(2'b00, 2'b10, 0, 0, 0, "t2_wb_fwd_b");
      issue(1, 1, 2, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t2_x0_add_id");
      nop(2'b00, 2'b00, 0, 0, 0, "t2_x0_add_in_ex");
      issue(1, 4, 0, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t2_x0_in_mem");
      nop(2'b00, 2'b00, 0, 0, 0, "t2_x0_no_fwd");

      // 3: double hazard, MEM wins
      do_reset("t3_reset");
      issue(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t3_add_id");
      issue(1, 5, 0, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, "t3_add_in_ex");
      issue(1, 5, 5, 8, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, "t3_addi_fwd");
      nop(2'b01, 2'b01, 0, 0, 0, "t3_mem_beats_wb");

      // 4: load-use stall, then independent consumer of a load
      do_reset("t4_reset");
      issue(1, 1, 0, 9, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, "t4_lw_id");
      issue(1, 9, 1, 10, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, "t4_stall");
      issue(1, 9, 1, 10, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, "t4_stall_once");
      nop(2'b10, 2'b00, 0, 1, 0, "t4_load_fwd_wb");
      issue(1, 1, 0, 9, 1, 1, 0, 2'b00, 2'b00, 0, 1, 0, "t4_lw2_id");
      issue(1, 1, 2, 10, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, "t4_no_stall_indep");
      nop(2'b00, 2'b00, 0, 1, 0, "t4_indep_in_ex");

      // 5: flush coincident with load-use
      do_reset("t5_reset");
      issue(1, 1, 0, 9, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, "t5_lw_id");
      issue(1, 9, 1, 10, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, "t5_flush_over_stall");
      issue(1, 9, 10, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, "t5_bubble_ex");
      nop(2'b00, 2'b00, 0, 0, 1, "t5_no_fwd_squashed");
      nop(2'b00, 2'b00, 0, 0, 1, "t5_after_flush");

      // 6: asynchronous reset in the middle of a stall
      do_reset("t6_reset");
      issue(1, 1, 2, 5, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, "t6_flush");
      issue(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1, "t6_add_id");
      issue(1, 5, 0, 9, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, "t6_lw_id");
      issue(1, 9, 1, 10, 1, 0, 0, 2'b01, 2'b00, 1, 0, 1, "t6_mid_stall");
      do_reset("t6_async_rst");

      // 6b: chained dependent loads stall every other cycle; counter sticks at 15
      for (int i = 0; i < 36; i++) begin
         issue(1, 9, 0, 9, 1, 1, 0,
               ((i >= 3) && (i % 2 == 1)) ? 2'b10 : 2'b00, 2'b00,
               (i % 2 == 1), (i / 2 > 15) ? 15 : i / 2, 0, "t6_sat");
      end

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
